id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL use clock and reset as decided: one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 if_valid  in  1  if_instr holds a valid fetched instruction.
REQ-005 if_instr  in  32  instruction word from fetch; upstream holds it while if_ready=0.
REQ-006 if_ready  out  1  ID accepts if_instr this cycle; a transfer occurs when if_valid && if_ready.
REQ-007 flush  in  1  branch taken downstream; discard the instruction in ID.
REQ-008 wb_we / wb_addr / wb_data  in  1/5/32  register-file write port from writeback.
REQ-009 ex_valid  out  1  ID/EX register holds a real instruction; 0 means bubble.
REQ-010 data1 / read2 / instruction  out  32 each  rs value, rt value, raw instruction word for the ALU.
REQ-011 ALUSrc  out  1  1 selects the sign-extended imm16 as ALU operand 2.
REQ-012 ALUcontrol  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
REQ-013 ex_rd  out  5  destination register.
REQ-014 ex_regwrite / ex_memread / ex_memwrite / ex_branch  out  1 each  downstream control bits.
REQ-015 illegal  out  1  one-cycle pulse when an accepted instruction fails to decode.

Function
REQ-016 Register file: 32x32; two combinational reads (rs=[25:21], rt=[20:16]); one write on clk when wb_we.
- r0 reads 0; writes to r0 are ignored.
- Same-cycle write and read of the same nonzero address returns wb_data (write-through bypass).
REQ-017 Decode, R-type (opcode 0), by funct -> ALUcontrol; all set ALUSrc=0, regwrite=1, rd=[15:11]:
- 0x20 -> 0010; 0x22 -> 0110; 0x24 -> 0000; 0x25 -> 0001; 0x27 -> 1100; 0x2A -> 0111.
REQ-018 Decode, I-type (ALUSrc=1, rd=rt, unless stated):
- lw 0x23: ADD, regwrite, memread.
- sw 0x2B: ADD, memwrite.
- addi 0x08: ADD, regwrite. andi 0x0C: AND, regwrite. ori 0x0D: OR, regwrite. slti 0x0A: SLT, regwrite.
- beq 0x04: SUB, ALUSrc=0, branch.
REQ-019 Any other opcode/funct SHALL load a bubble into ID/EX and pulse illegal the next cycle.
REQ-020 Latency SHALL be one cycle: an instruction accepted at edge N appears on the outputs after edge N.
REQ-021 Load-use hazard SHALL be detected when all of the following hold:
- ex_valid && ex_memread && ex_rd!=0;
- ex_rd==rs, or ex_rd==rt with an rt-reading instruction (R-type, sw, beq).
REQ-022 On hazard (no flush): if_ready=0; ID/EX loads a bubble; the instruction is re-presented and accepted the next cycle.
REQ-023 On flush: ID/EX loads a bubble and if_ready=1, so the instruction in ID is consumed and dropped; flush has priority over hazard.
REQ-024 If if_valid=0 with no stall, ID/EX SHALL load a bubble.
REQ-025 A bubble SHALL force ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch to 0; the data outputs are don't-care.

Reset
REQ-026 When rst=1 at an edge: all 32 registers, all outputs and the ID/EX register SHALL be 0; illegal=0.
REQ-027 if_ready SHALL be 1 during and after reset.
REQ-028 A reset mid-stall SHALL drop the stalled instruction and the load in EX.
REQ-029 A wb write coincident with rst SHALL be ignored.

Structure
REQ-030 A shared package SHALL hold the opcode/funct constants, the ALUcontrol encodings and the register count.
REQ-031 The register file SHALL be a separate sub-module, regfile.
REQ-032 Decode, hazard logic and the ID/EX register SHALL live in id_stage.

Verification
REQ-033 Reset, then write r5=0x0000_00AA; issue add r3,r5,r0 (0x00A01820) -> data1=0xAA, read2=0, ALUcontrol=0010, ex_rd=3, ex_regwrite=1.
REQ-034 Same-cycle wb r7=0x1234 and issue or r1,r7,r7 -> data1=read2=0x1234 (bypass); a write to r0 keeps r0 reading 0.
REQ-035 lw r2,4(r1) followed by add r4,r2,r2 -> one cycle with if_ready=0 and ex_valid=0, then add issues; a following lw/sw pair with no dependence -> no stall.
REQ-036 Assert flush while beq is in EX and sub is in ID -> next cycle ex_valid=0 and sub never appears; flush during a load-use stall -> bubble with if_ready=1.
REQ-037 Opcode 0x3F -> illegal=1 for exactly one cycle, ex_valid=0; slti r9,r8,-1 -> ALUSrc=1, ALUcontrol=0111, ex_rd=9.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared constants for the decode stage: opcodes, funct codes, ALU encodings and
// the ID/EX pipeline register layout.
package id_stage_pkg;

    localparam int unsigned NumRegs  = 32;
    localparam int unsigned RegAddrW = 5;

    localparam logic [5:0] OpRType = 6'h00;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpBeq   = 6'h04;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnNor = 6'h27;
    localparam logic [5:0] FnSlt = 6'h2A;

    typedef enum logic [3:0] {
        AluAnd = 4'b0000,
        AluOr  = 4'b0001,
        AluAdd = 4'b0010,
        AluSub = 4'b0110,
        AluSlt = 4'b0111,
        AluNor = 4'b1100
    } alu_ctrl_e;

    typedef struct packed {
        logic                legal;
        logic                alu_src;
        alu_ctrl_e           alu_ctrl;
        logic [RegAddrW-1:0] rd;
        logic                reads_rt;
        logic                regwrite;
        logic                memread;
        logic                memwrite;
        logic                branch;
    } dec_t;

    typedef struct packed {
        logic                valid;
        logic [31:0]         data1;
        logic [31:0]         read2;
        logic [31:0]         instr;
        logic                alu_src;
        alu_ctrl_e           alu_ctrl;
        logic [RegAddrW-1:0] rd;
        logic                regwrite;
        logic                memread;
        logic                memwrite;
        logic                branch;
    } idex_t;

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two combinational read ports with write-through bypass,
// one synchronous write port. r0 is hardwired to zero.
module regfile
    import id_stage_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                we_i,
    input  logic [RegAddrW-1:0] waddr_i,
    input  logic [31:0]         wdata_i,
    input  logic [RegAddrW-1:0] raddr1_i,
    input  logic [RegAddrW-1:0] raddr2_i,
    output logic [31:0]         rdata1_o,
    output logic [31:0]         rdata2_o
);

    logic [31:0] regs_q [NumRegs];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        if (raddr1_i == '0) begin
            rdata1_o = '0;
        end else if (we_i && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end else begin
            rdata1_o = regs_q[raddr1_i];
        end

        if (raddr2_i == '0) begin
            rdata2_o = '0;
        end else if (we_i && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end else begin
            rdata2_o = regs_q[raddr2_i];
        end
    end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: decode, load-use hazard stall, flush handling and
// the ID/EX pipeline register.
module id_stage
    import id_stage_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                if_valid_i,
    input  logic [31:0]         if_instr_i,
    output logic                if_ready_o,
    input  logic                flush_i,
    input  logic                wb_we_i,
    input  logic [RegAddrW-1:0] wb_addr_i,
    input  logic [31:0]         wb_data_i,
    output logic                ex_valid_o,
    output logic [31:0]         data1_o,
    output logic [31:0]         read2_o,
    output logic [31:0]         instruction_o,
    output logic                alu_src_o,
    output logic [3:0]          alu_control_o,
    output logic [RegAddrW-1:0] ex_rd_o,
    output logic                ex_regwrite_o,
    output logic                ex_memread_o,
    output logic                ex_memwrite_o,
    output logic                ex_branch_o,
    output logic                illegal_o
);

    logic [RegAddrW-1:0] rs_addr, rt_addr;
    logic [31:0]         rs_val, rt_val;
    logic [5:0]          opcode, funct;
    dec_t                dec;
    idex_t               idex_q, idex_d;
    logic                illegal_q, illegal_d;
    logic                hazard, stall, load;

    assign rs_addr = if_instr_i[25:21];
    assign rt_addr = if_instr_i[20:16];
    assign opcode  = if_instr_i[31:26];
    assign funct   = if_instr_i[5:0];

    regfile u_regfile (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .we_i     (wb_we_i),
        .waddr_i  (wb_addr_i),
        .wdata_i  (wb_data_i),
        .raddr1_i (rs_addr),
        .raddr2_i (rt_addr),
        .rdata1_o (rs_val),
        .rdata2_o (rt_val)
    );

    always_comb begin
        dec          = '0;
        dec.alu_ctrl = AluAdd;
        dec.alu_src  = 1'b1;
        dec.rd       = rt_addr;
        case (opcode)
            OpRType: begin
                dec.legal    = 1'b1;
                dec.alu_src  = 1'b0;
                dec.rd       = if_instr_i[15:11];
                dec.reads_rt = 1'b1;
                dec.regwrite = 1'b1;
                case (funct)
                    FnAdd:   dec.alu_ctrl = AluAdd;
                    FnSub:   dec.alu_ctrl = AluSub;
                    FnAnd:   dec.alu_ctrl = AluAnd;
                    FnOr:    dec.alu_ctrl = AluOr;
                    FnNor:   dec.alu_ctrl = AluNor;
                    FnSlt:   dec.alu_ctrl = AluSlt;
                    default: begin
                        dec.legal    = 1'b0;
                        dec.regwrite = 1'b0;
                    end
                endcase
            end
            OpLw: begin
                dec.legal    = 1'b1;
                dec.regwrite = 1'b1;
                dec.memread  = 1'b1;
            end
            OpSw: begin
                dec.legal    = 1'b1;
                dec.reads_rt = 1'b1;
                dec.memwrite = 1'b1;
            end
            OpAddi: begin
                dec.legal    = 1'b1;
                dec.regwrite = 1'b1;
            end
            OpAndi: begin
                dec.legal    = 1'b1;
                dec.alu_ctrl = AluAnd;
                dec.regwrite = 1'b1;
            end
            OpOri: begin
                dec.legal    = 1'b1;
                dec.alu_ctrl = AluOr;
                dec.regwrite = 1'b1;
            end
            OpSlti: begin
                dec.legal    = 1'b1;
                dec.alu_ctrl = AluSlt;
                dec.regwrite = 1'b1;
            end
            OpBeq: begin
                dec.legal    = 1'b1;
                dec.alu_src  = 1'b0;
                dec.alu_ctrl = AluSub;
                dec.reads_rt = 1'b1;
                dec.branch   = 1'b1;
            end
            default: dec.legal = 1'b0;
        endcase
    end

    // Load-use: the load in EX writes a register this instruction reads.
    always_comb begin
        hazard = idex_q.valid && idex_q.memread && (idex_q.rd != '0) &&
                 ((idex_q.rd == rs_addr) || (dec.reads_rt && (idex_q.rd == rt_addr)));
        stall  = if_valid_i && hazard && !flush_i;
        load   = if_valid_i && !stall && !flush_i;
    end

    assign if_ready_o = rst_i || !stall;

    always_comb begin
        idex_d       = '0;
        idex_d.valid = load && dec.legal;
        if (idex_d.valid) begin
            idex_d.data1    = rs_val;
            idex_d.read2    = rt_val;
            idex_d.instr    = if_instr_i;
            idex_d.alu_src  = dec.alu_src;
            idex_d.alu_ctrl = dec.alu_ctrl;
            idex_d.rd       = dec.rd;
            idex_d.regwrite = dec.regwrite;
            idex_d.memread  = dec.memread;
            idex_d.memwrite = dec.memwrite;
            idex_d.branch   = dec.branch;
        end
        illegal_d = load && !dec.legal;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idex_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            idex_q    <= idex_d;
            illegal_q <= illegal_d;
        end
    end

    assign ex_valid_o    = idex_q.valid;
    assign data1_o       = idex_q.data1;
    assign read2_o       = idex_q.read2;
    assign instruction_o = idex_q.instr;
    assign alu_src_o     = idex_q.alu_src;
    assign alu_control_o = idex_q.alu_ctrl;
    assign ex_rd_o       = idex_q.rd;
    assign ex_regwrite_o = idex_q.regwrite;
    assign ex_memread_o  = idex_q.memread;
    assign ex_memwrite_o = idex_q.memwrite;
    assign ex_branch_o   = idex_q.branch;
    assign illegal_o     = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: a driver predicts each cycle's ID/EX contents from
// an architectural model and queues them; a monitor compares after every edge.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_instr = '0;
    logic        if_ready;
    logic        flush = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        ex_valid, alu_src, ex_regwrite, ex_memread, ex_memwrite, ex_branch, illegal;
    logic [31:0] data1, read2, instruction;
    logic [3:0]  alu_control;
    logic [4:0]  ex_rd;

    always #5 clk = ~clk;

    id_stage dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .if_valid_i    (if_valid),
        .if_instr_i    (if_instr),
        .if_ready_o    (if_ready),
        .flush_i       (flush),
        .wb_we_i       (wb_we),
        .wb_addr_i     (wb_addr),
        .wb_data_i     (wb_data),
        .ex_valid_o    (ex_valid),
        .data1_o       (data1),
        .read2_o       (read2),
        .instruction_o (instruction),
        .alu_src_o     (alu_src),
        .alu_control_o (alu_control),
        .ex_rd_o       (ex_rd),
        .ex_regwrite_o (ex_regwrite),
        .ex_memread_o  (ex_memread),
        .ex_memwrite_o (ex_memwrite),
        .ex_branch_o   (ex_branch),
        .illegal_o     (illegal)
    );

    typedef struct packed {
        bit        legal, alusrc, rrt, rw, mr, mw, br;
        bit [3:0]  ctl;
        bit [4:0]  rd;
    } dec_s;

    typedef struct packed {
        bit        is_rst, valid, illegal, alusrc, rw, mr, mw, br;
        bit [31:0] data1, read2, instr;
        bit [3:0]  ctl;
        bit [4:0]  rd;
    } exp_s;

    exp_s      sb[$];
    bit [31:0] m_regs [32];
    bit        p_valid, p_mr;
    bit [4:0]  p_rd;
    int        total = 0;
    int        bad = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
        end
    endfunction

    // Architectural decode table.
    function automatic dec_s ref_dec(bit [31:0] ins);
        dec_s     d;
        bit [5:0] op;
        bit [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        d = '0;
        d.legal = 1'b1;
        d.alusrc = 1'b1;
        d.rd = ins[20:16];
        case (op)
            6'h00: begin
                d.alusrc = 1'b0; d.rrt = 1'b1; d.rw = 1'b1; d.rd = ins[15:11];
                case (fn)
                    6'h20: d.ctl = 4'b0010;
                    6'h22: d.ctl = 4'b0110;
                    6'h24: d.ctl = 4'b0000;
                    6'h25: d.ctl = 4'b0001;
                    6'h27: d.ctl = 4'b1100;
                    6'h2A: d.ctl = 4'b0111;
                    default: d.legal = 1'b0;
                endcase
            end
            6'h23: begin d.ctl = 4'b0010; d.rw = 1'b1; d.mr = 1'b1; end
            6'h2B: begin d.ctl = 4'b0010; d.mw = 1'b1; d.rrt = 1'b1; end
            6'h08: begin d.ctl = 4'b0010; d.rw = 1'b1; end
            6'h0C: begin d.ctl = 4'b0000; d.rw = 1'b1; end
            6'h0D: begin d.ctl = 4'b0001; d.rw = 1'b1; end
            6'h0A: begin d.ctl = 4'b0111; d.rw = 1'b1; end
            6'h04: begin d.ctl = 4'b0110; d.alusrc = 1'b0; d.br = 1'b1; d.rrt = 1'b1; end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    function automatic bit [31:0] rd_val(bit [4:0] a, bit we, bit [4:0] wa, bit [31:0] wd);
        if (a == 0) return 32'h0;
        if (we && wa == a) return wd;
        return m_regs[a];
    endfunction

    // One clock cycle: drive, predict, check if_ready, queue the expected ID/EX contents.
    task automatic step(input bit r, input bit v, input bit [31:0] ins, input bit fl,
                        input bit we, input bit [4:0] wa, input bit [31:0] wd, output bit took);
        exp_s e;
        dec_s d;
        bit   haz, stall, ld, exp_ready;
        @(negedge clk);
        rst = r; if_valid = v; if_instr = ins; flush = fl;
        wb_we = we; wb_addr = wa; wb_data = wd;
        #1;
        e = '0;
        if (r) begin
            e.is_rst = 1'b1;
            exp_ready = 1'b1;
            took = 1'b1;
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            p_valid = 1'b0; p_mr = 1'b0; p_rd = '0;
        end else begin
            d = ref_dec(ins);
            haz = p_valid && p_mr && p_rd != 0 &&
                  (p_rd == ins[25:21] || (d.rrt && p_rd == ins[20:16]));
            stall = v && haz && !fl;
            exp_ready = !stall;
            took = v && !stall;
            ld = took && !fl;
            e.valid = ld && d.legal;
            e.illegal = ld && !d.legal;
            if (e.valid) begin
                e.data1 = rd_val(ins[25:21], we, wa, wd);
                e.read2 = rd_val(ins[20:16], we, wa, wd);
                e.instr = ins; e.alusrc = d.alusrc; e.ctl = d.ctl; e.rd = d.rd;
                e.rw = d.rw; e.mr = d.mr; e.mw = d.mw; e.br = d.br;
            end
            if (we && wa != 0) m_regs[wa] = wd;
            p_valid = e.valid; p_mr = e.mr; p_rd = e.rd;
        end
        chk("if_ready", {31'b0, if_ready}, {31'b0, exp_ready});
        sb.push_back(e);
    endtask

    task automatic issue(input bit [31:0] ins);
        bit t;
        int n;
        n = 0;
        do begin
            step(1'b0, 1'b1, ins, 1'b0, 1'b0, 5'd0, 32'd0, t);
            n++;
        end while (!t && n < 4);
        if (!t) chk("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        bit t;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, t);
    endtask

    function automatic bit [31:0] rand_instr();
        bit [4:0]  rs, rt, rd;
        bit [15:0] imm;
        bit [5:0]  fns [6];
        bit [5:0]  ops [7];
        int        k;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
        ops = '{6'h23, 6'h2B, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h04};
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        k = $urandom_range(0, 19);
        if (k < 7) return {6'h00, rs, rt, rd, 5'd0, fns[$urandom_range(0, 5)]};
        if (k < 18) return {ops[$urandom_range(0, 6)], rs, rt, imm};
        if (k == 18) return {6'h00, rs, rt, rd, 5'd0, 6'h3E};
        return {6'h3F, rs, rt, imm};
    endfunction

    // Monitor: one expectation per clock edge once the driver is running.
    initial begin
        exp_s e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ex_valid", {31'b0, ex_valid}, {31'b0, e.valid});
                chk("illegal", {31'b0, illegal}, {31'b0, e.illegal});
                chk("ex_regwrite", {31'b0, ex_regwrite}, {31'b0, e.rw});
                chk("ex_memread", {31'b0, ex_memread}, {31'b0, e.mr});
                chk("ex_memwrite", {31'b0, ex_memwrite}, {31'b0, e.mw});
                chk("ex_branch", {31'b0, ex_branch}, {31'b0, e.br});
                if (e.valid || e.is_rst) begin
                    chk("data1", data1, e.data1);
                    chk("read2", read2, e.read2);
                    chk("instruction", instruction, e.instr);
                    chk("alu_src", {31'b0, alu_src}, {31'b0, e.alusrc});
                    chk("alu_control", {28'b0, alu_control}, {28'b0, e.ctl});
                    chk("ex_rd", {27'b0, ex_rd}, {27'b0, e.rd});
                end
            end
        end
    end

    initial begin
        bit        t, r, v, fl, we;
        bit [31:0] pend;
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, t);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, t);

        // add r3,r5,r0 after r5=0xAA
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 5'd5, 32'h0000_00AA, t);
        issue(32'h00A0_1820);
        // or r1,r7,r7 with same-cycle write of r7; then r0 write ignored
        step(1'b0, 1'b1, 32'h00E7_0825, 1'b0, 1'b1, 5'd7, 32'h0000_1234, t);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, t);
        issue(32'h0000_1020);
        // lw r2 then dependent add: one stall; then independent lw/sw
        issue(32'h8C22_0004);
        issue(32'h0042_2020);
        issue(32'h8C25_0000);
        issue(32'hAC26_0008);
        // beq then flushed sub; flush during a load-use stall
        issue(32'h1022_0003);
        step(1'b0, 1'b1, 32'h0022_4022, 1'b1, 1'b0, 5'd0, 32'd0, t);
        issue(32'h8C22_0004);
        step(1'b0, 1'b1, 32'h0042_2020, 1'b1, 1'b0, 5'd0, 32'd0, t);
        // illegal opcode pulse, then slti r9,r8,-1
        issue(32'hFC00_0000);
        idle(1);
        issue(32'h2909_FFFF);
        // reset mid-stall, and a wb write coincident with reset
        issue(32'h8C22_0004);
        step(1'b0, 1'b1, 32'h0042_2020, 1'b0, 1'b0, 5'd0, 32'd0, t);
        step(1'b1, 1'b1, 32'h0042_2020, 1'b0, 1'b1, 5'd5, 32'h5555_5555, t);
        idle(1);
        issue(32'h00A0_1820);

        pend = rand_instr();
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 99) < 2);
            v  = ($urandom_range(0, 99) < 85);
            fl = ($urandom_range(0, 99) < 8);
            we = ($urandom_range(0, 1) == 1);
            step(r, v, pend, fl, we, 5'($urandom_range(0, 7)), $urandom, t);
            if (t && (v || r)) pend = rand_instr();
        end

        idle(2);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
